// File: rtl/mips64_mem_pkg.sv
// Shared encodings for the MIPS64 data-memory access unit: access sizes,
// FSM states and the alignment rule.
package mips64_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    MRG  = 3'd3,
    WR   = 3'd4,
    RESP = 3'd5
  } state_e;

  // An access is misaligned when the byte offset is not a multiple of its size.
  function automatic logic misaligned(size_e sz, logic [2:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      SZ_D:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane extraction/extension for loads and lane merge for
// read-modify-write stores. Purely combinational.
module mem_lane_align
  import mips64_mem_pkg::*;
(
  input  size_e       size,
  input  logic [2:0]  offset,
  input  logic        sign_ext,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merge_data
);

  logic [63:0] lane_mask;
  logic [63:0] lane;
  logic [2:0]  n_mod8;
  logic [5:0]  shamt;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    lane_mask  = '1;
    n_mod8     = 3'd0;
    load_data  = '0;
    case (size)
      SZ_B: begin lane_mask = 64'h0000_0000_0000_00FF; n_mod8 = 3'd1; end
      SZ_H: begin lane_mask = 64'h0000_0000_0000_FFFF; n_mod8 = 3'd2; end
      SZ_W: begin lane_mask = 64'h0000_0000_FFFF_FFFF; n_mod8 = 3'd4; end
      default: ;
    endcase

    // Lane sits 8*(8-o-n) bits above bit 0; mod-8 arithmetic covers n = 8.
    shamt = {3'd0 - offset - n_mod8, 3'b000};
    lane  = (rdata >> shamt) & lane_mask;

    case (size)
      SZ_B:    load_data = {{56{sign_ext & lane[7]}},  lane[7:0]};
      SZ_H:    load_data = {{48{sign_ext & lane[15]}}, lane[15:0]};
      SZ_W:    load_data = {{32{sign_ext & lane[31]}}, lane[31:0]};
      default: load_data = lane;
    endcase

    merge_data = (rdata & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one request at a time, performs aligned loads,
// doubleword stores and read-modify-write sub-doubleword stores.
module mem_access_unit
  import mips64_mem_pkg::*;
#(
  parameter int ADDR_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [63:0]          req_wdata,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [63:0]          resp_rdata,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [63:0]          mem_din,
  input  logic [63:0]          mem_dout
);

  state_e               state, state_nx;
  logic [ADDR_BITS-1:0] addr_q;
  size_e                size_q;
  logic                 signed_q;
  logic                 wr_q;
  logic [63:0]          wdata_q;
  logic                 err_q;
  logic [63:0]          rdata_q;

  logic                 accept;
  logic                 req_mis;
  logic [63:0]          load_data;
  logic [63:0]          merge_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_mis   = misaligned(size_e'(req_size), req_addr[2:0]);

  mem_lane_align u_align (
    .size       (size_q),
    .offset     (addr_q[2:0]),
    .sign_ext   (signed_q),
    .rdata      (mem_dout),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      state <= state_nx;
      if (accept) begin
        addr_q   <= req_addr;
        size_q   <= size_e'(req_size);
        signed_q <= req_signed;
        wr_q     <= req_wr;
        wdata_q  <= req_wdata;
        err_q    <= req_mis;
        rdata_q  <= '0;
      end else if (state == CAP) begin
        rdata_q <= load_data;
      end
    end
  end

  // Memory strobes decode straight from state, so a reset drops a pending MRG write.
  always_comb begin
    state_nx   = state;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_din    = '0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_mis)                  state_nx = RESP;
          else if (!req_wr)             state_nx = RD;
          else if (req_size == SZ_D)    state_nx = WR;
          else                          state_nx = RD;
        end
      end
      RD: begin
        mem_en   = 1'b1;
        state_nx = wr_q ? MRG : CAP;
      end
      CAP: state_nx = RESP;
      MRG: begin
        mem_en   = 1'b1;
        mem_wr   = 1'b1;
        mem_din  = merge_data;
        state_nx = RESP;
      end
      WR: begin
        mem_en   = 1'b1;
        mem_wr   = 1'b1;
        mem_din  = wdata_q;
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_addr   = {3'b000, addr_q[ADDR_BITS-1:3]};
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level reference memory model,
// directed scenarios followed by random load/store traffic.
module tb_mem_access_unit;
  import mips64_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [63:0] mem_addr;
  logic [63:0] mem_din;
  logic [63:0] mem_dout = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          rds;
    int          wrs;
    logic [63:0] maddr;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_resp_cyc = -100;
  logic [7:0]  ref_bytes [128];
  logic [63:0] mem_init [16];
  logic [63:0] mem [16];
  bit          init_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory: 16 doublewords, one-cycle read latency.
  initial begin
    wait (init_done);
    for (int d = 0; d < 16; d++) mem[d] = mem_init[d];
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_wr) mem[mem_addr[3:0]] = mem_din;
        else        mem_dout <= mem[mem_addr[3:0]];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: memory is a flat byte array; byte a is the most significant of its group.
  function automatic logic [63:0] ref_dw(int d);
    logic [63:0] v = '0;
    for (int j = 0; j < 8; j++) v = (v << 8) | 64'(ref_bytes[8*d + j]);
    return v;
  endfunction

  function automatic logic [63:0] ref_load(logic [63:0] a, int n, logic sgn);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_bytes[7'(a + 64'(i))]);
    if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input int n, input logic [63:0] wd);
    for (int i = 0; i < n; i++) ref_bytes[7'(a + 64'(i))] = wd[8*(n-1-i) +: 8];
  endtask

  // Monitor: counts memory traffic and scores every response.
  initial begin
    exp_t e;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (mem_en) begin
          if (mem_wr) wr_cnt++;
          else        rd_cnt++;
          if (exp_q.size() > 0) check("mem_addr", mem_addr, exp_q[0].maddr);
        end
        if (!mem_wr) check("mem_din_quiet", mem_din, 64'd0);
        if (resp_valid) begin
          check("ready_during_resp", 64'(req_ready), 64'd0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: actual=resp_valid required=no response");
          end else begin
            e = exp_q.pop_front();
            check("resp_err",   64'(resp_err), 64'(e.err));
            check("resp_rdata", resp_rdata, e.rdata);
            check("latency",    64'(cyc - e.acc_cyc), 64'(e.lat));
            check("mem_reads",  64'(rd_cnt), 64'(e.rds));
            check("mem_writes", 64'(wr_cnt), 64'(e.wrs));
          end
          last_resp_cyc = cyc;
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  // Driver: called at a negedge, returns at the negedge after acceptance.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input bit b2b, input bit track);
    exp_t       e;
    int         n;
    int         budget = 50;
    logic [2:0] m;
    req_valid  = 1'b1;
    req_wr     = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: actual=req_ready low required=accept within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    if (b2b) check("b2b_accept_cycle", 64'(cyc), 64'(last_resp_cyc + 1));
    n = 1 << sz;
    m = 3'(n - 1);
    e.err     = (addr[2:0] & m) != 3'd0;
    e.maddr   = {3'b000, addr[63:3]};
    e.acc_cyc = cyc;
    e.rdata   = '0;
    if (e.err) begin
      e.lat = 1; e.rds = 0; e.wrs = 0;
    end else if (wr) begin
      e.lat = (n == 8) ? 2 : 3;
      e.rds = (n == 8) ? 0 : 1;
      e.wrs = 1;
      if (track) ref_store(addr, n, wd);
    end else begin
      e.lat = 3; e.rds = 1; e.wrs = 0;
      e.rdata = ref_load(addr, n, sgn);
    end
    if (track) exp_q.push_back(e);
    @(negedge clk);
    req_valid  = 1'b0;
    req_wr     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    int          budget;

    for (int i = 0; i < 128; i++) ref_bytes[i] = 8'($urandom);
    for (int d = 0; d < 16; d++) mem_init[d] = ref_dw(d);
    init_done = 1'b1;

    #2;
    check("rst_ready",      64'(req_ready),  64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err",   64'(resp_err),   64'd0);
    check("rst_resp_rdata", resp_rdata,      64'd0);
    check("rst_mem_en",     64'(mem_en),     64'd0);
    check("rst_mem_wr",     64'(mem_wr),     64'd0);
    check("rst_mem_din",    mem_din,         64'd0);
    check("rst_mem_addr",   mem_addr,        64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Doubleword round trip, lane extraction, byte RMW, misaligned word.
    issue(1'b1, SZ_D, 1'b0, 64'h40, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    issue(1'b0, SZ_D, 1'b0, 64'h40, 64'h0, 1'b1, 1'b1);
    issue(1'b0, SZ_B, 1'b1, 64'h47, 64'h0, 1'b1, 1'b1);
    issue(1'b0, SZ_B, 1'b0, 64'h47, 64'h0, 1'b1, 1'b1);
    issue(1'b0, SZ_H, 1'b1, 64'h40, 64'h0, 1'b1, 1'b1);
    issue(1'b1, SZ_B, 1'b0, 64'h42, 64'hFFFF_FFFF_FFFF_FFAA, 1'b1, 1'b1);
    issue(1'b0, SZ_D, 1'b0, 64'h40, 64'h0, 1'b1, 1'b1);
    issue(1'b0, SZ_W, 1'b0, 64'h41, 64'h0, 1'b1, 1'b1);
    issue(1'b1, SZ_D, 1'b0, 64'h40, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
    issue(1'b0, SZ_W, 1'b1, 64'h40, 64'h0, 1'b1, 1'b1);
    issue(1'b0, SZ_W, 1'b1, 64'h44, 64'h0, 1'b1, 1'b1);
    // Top of the address space: no carry into mem_addr.
    issue(1'b1, SZ_B, 1'b0, '1, 64'h5A, 1'b1, 1'b1);
    issue(1'b0, SZ_B, 1'b1, '1, 64'h0, 1'b1, 1'b1);

    // Reset while a byte store sits in RD: the request must vanish.
    issue(1'b1, SZ_B, 1'b0, 64'h4A, 64'h77, 1'b1, 1'b0);
    check("abandon_in_rd", 64'({mem_en, mem_wr}), 64'b10);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_mem_wr", 64'(mem_wr),     64'd0);
      check("rst_no_resp",   64'(resp_valid), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 64'(req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_mem_wr", 64'(mem_wr),     64'd0);
      check("post_rst_no_resp",   64'(resp_valid), 64'd0);
    end

    // Random traffic, mostly aligned, fully random upper address bits.
    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom);
      a  = {$urandom, $urandom};
      if ($urandom_range(3) != 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      issue(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, (t != 0), 1'b1);
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: actual=%0d pending required=0 pending", exp_q.size());
    end

    @(negedge clk);
    for (int d = 0; d < 16; d++) check($sformatf("mem_final_%0d", d), mem[d], ref_dw(d));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 64, byte-address width of the request port.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  load/store request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_wr  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_signed  input  1  sign-extend load result; ignored for stores and doubleword.
- req_addr  input  ADDR_BITS  byte address.
- req_wdata  input  64  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  misaligned access, valid with resp_valid.
- resp_rdata  output  64  extended load data, valid with resp_valid; 0 for stores and errors.
- mem_en  output  1  data memory enable.
- mem_wr  output  1  data memory write.
- mem_addr  output  ADDR_BITS  doubleword index = {3'b0, req_addr[ADDR_BITS-1:3]}.
- mem_din  output  64  data memory write data.
- mem_dout  input  64  data memory read data, valid the cycle after mem_en with mem_wr = 0.

Function
REQ-003 SHALL accept a request when req_valid && req_ready; req_ready SHALL be 1 only in IDLE.
REQ-004 SHALL latch addr, size, signed, wr and wdata at acceptance; later input changes SHALL have no effect.
REQ-005 SHALL implement states IDLE, RD, CAP, MRG, WR and RESP.
REQ-006 Transitions on accept: misaligned → RESP; load → RD → CAP → RESP; doubleword store → WR → RESP; sub-doubleword store → RD → MRG → RESP; RESP → IDLE unconditionally.
REQ-007 Misaligned SHALL mean: half with addr[0] ≠ 0; word with addr[1:0] ≠ 0; doubleword with addr[2:0] ≠ 0. No mem_en SHALL be issued for a misaligned access.
REQ-008 mem_en SHALL be 1 only in RD, MRG and WR; mem_wr SHALL be 1 only in MRG and WR; mem_din SHALL be 0 outside MRG and WR.
REQ-009 Byte lanes SHALL be big-endian: for offset o = addr[2:0] and size n bytes, the lane is bits [63-8o : 64-8(o+n)].
REQ-010 In CAP, the unit SHALL extract the lane from mem_dout, extend it (sign if req_signed, else zero), and register the result into resp_rdata.
REQ-011 In MRG, mem_din SHALL be mem_dout with only the addressed lane replaced by the low 8n bits of wdata (read-modify-write). In WR, mem_din SHALL be wdata.
REQ-012 resp_valid SHALL be 1 only in RESP, for exactly one cycle.
REQ-013 Latency from the accept cycle to resp_valid: misaligned 1 cycle, doubleword store 2 cycles, load and sub-doubleword store 3 cycles.
REQ-014 Back-to-back operation: the next request SHALL be accepted in the IDLE cycle after RESP. A store followed by a load to the same doubleword SHALL return the stored data.
REQ-015 The top address: req_addr = all-ones (byte size) SHALL map to mem_addr = {3'b0, all-ones}; there SHALL be no wrap or carry.

Reset
REQ-016 On rst_n low, regardless of clk: state = IDLE; resp_valid, resp_err, resp_rdata, mem_en, mem_wr, mem_din and all latched fields = 0; req_ready = 1 after deassertion.
REQ-017 Reset mid-operation SHALL abandon the request without a response. A write already clocked into memory is not undone; an MRG write not yet clocked SHALL NOT occur.

Structure
REQ-018 Package mips64_mem_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the state enumeration.
REQ-019 Lane extract/extend and merge logic SHALL be one combinational sub-module, mem_lane_align; the FSM and registers SHALL remain in mem_access_unit.

Verification
REQ-020 Doubleword store of 0x0123456789ABCDEF at 0x40, then doubleword load at 0x40 → mem_addr = 8; rdata = 0x0123456789ABCDEF; store resp 2 cycles after accept, load resp 3 cycles after accept.
REQ-021 With 0x0123456789ABCDEF at doubleword 8: signed byte load at 0x47 → 0xFFFFFFFFFFFFFFEF; unsigned → 0xEF; signed half at 0x40 → 0x0123.
REQ-022 Byte store of 0xAA at 0x42 over the same data → memory holds 0x0123AA6789ABCDEF; one read and one write issued.
REQ-023 Word load at 0x41 → resp_err = 1 one cycle after accept; rdata = 0; mem_en never asserted.
REQ-024 Assert rst_n low during RD of a byte store → no mem_wr pulse; memory unchanged; resp_valid = 0; req_ready = 1 after release.
REQ-025 Two back-to-back signed word loads at 0x40 and 0x44 → 0x0000000001234567 then 0xFFFFFFFF89ABCDEF, second accepted in the cycle after the first RESP.
